instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage and IF/ID pipeline register of the 5-stage core. It is the initiator side of the instruction-memory interface: it drives a word-aligned byte address and samples the combinational 32-bit instruction returned in the same cycle. It holds the PC, applies stalls from decode and redirects from execute, and presents fetched instructions to decode with a valid flag.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSN, 32'h00000013, bubble instruction (addi x0,x0,0) placed in id_instr when the slot is flushed or empty.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_addr  output  32  byte address to instruction memory; equals current PC (combinational from PC register)
imem_instr  input  32  instruction word returned by memory for imem_addr, same cycle
id_ready  input  1  decode accepts the IF/ID slot this cycle (low = stall)
redirect_valid  input  1  execute requests PC change (branch/jump taken)
redirect_pc  input  32  redirect target byte address
id_valid  output  1  IF/ID slot holds a real instruction
id_instr  output  32  instruction in IF/ID slot
id_pc  output  32  address of id_instr
id_pc_plus4  output  32  id_pc + 4 (mod 2^32)
fetch_fault  output  1  sticky: misaligned redirect received
fetch_count  output  32  number of instructions accepted into IF/ID since reset

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=BOOT, id_valid=0, id_instr=NOP_INSN, id_pc=0, id_pc_plus4=0, fetch_fault=0, fetch_count=0. rst overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr = pc at all times, including BOOT and FAULT.
- States: BOOT, RUN, FAULT.
- BOOT: exactly one cycle after reset; no capture, id_valid stays 0, pc unchanged; inputs ignored; next state RUN.
- RUN, per edge, priority order:
  1. redirect_valid=1, redirect_pc[1:0]=0: pc<=redirect_pc; id_valid<=0; id_instr<=NOP_INSN; id_pc/id_pc_plus4 hold; fetch_count unchanged. Applies regardless of id_ready (flush overrides stall).
  2. redirect_valid=1, redirect_pc[1:0]!=0: state<=FAULT; fetch_fault<=1; id_valid<=0; id_instr<=NOP_INSN; pc holds.
  3. id_valid=1 and id_ready=0 (stall): all state holds; imem_addr stays at pc.
  4. Otherwise (advance): id_instr<=imem_instr; id_pc<=pc; id_pc_plus4<=pc+4; id_valid<=1; pc<=pc+4; fetch_count<=fetch_count+1.
- id_ready is ignored while id_valid=0 (empty slot always refills).
- FAULT: terminal until rst; id_valid=0, pc frozen, fetch_count frozen, redirect and id_ready ignored; fetch_fault stays 1.
- Latency: the instruction at address pc appears in IF/ID on the edge after pc is presented. Redirect sampled at edge N: id_valid=0 after N, target instruction valid after edge N+1.
- Arithmetic: pc+4 and fetch_count wrap modulo 2^32 with no flag (0xFFFFFFFC -> 0x00000000).
- imem_instr is only sampled on the advance path; X on imem_instr during stall, redirect or FAULT must not propagate.

Test Plan:
- Reset then 4 free-running cycles with memory words 0x00100093, 0x00200113, ... at 0x0, 0x4 -> id_valid=0 through BOOT; then id_pc=0x0/instr 0x00100093, then 0x4/0x00200113; fetch_count increments 1, 2.
- Hold id_ready=0 for 3 cycles while id_valid=1 at id_pc=0x8 -> id_pc, id_instr, imem_addr=0xC and fetch_count constant; release -> id_pc=0xC next edge.
- redirect_valid=1, redirect_pc=0x40 while id_ready=0 -> next cycle id_valid=0, id_instr=0x00000013, imem_addr=0x40; following cycle id_pc=0x40, id_valid=1.
- redirect_pc=0x42 -> fetch_fault=1, id_valid=0, pc frozen; later aligned redirect to 0x80 ignored; rst clears fault, pc=RESET_PC.
- Redirect to 0xFFFFFFFC -> id_pc=0xFFFFFFFC, id_pc_plus4=0x00000000, next imem_addr=0x00000000.
- Assert rst during a stall with id_valid=1 -> all outputs return to reset values next edge; BOOT repeats for one cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage plus IF/ID pipeline register: holds the PC, drives instruction memory,
// and applies decode stalls and execute redirects ahead of the decode stage.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic              id_valid_n;
    logic [XLEN-1:0]   id_instr_n, id_pc_n, id_pc_plus4_n, fetch_count_n;
    logic              fetch_fault_n;
    logic [XLEN-1:0]   pc_plus4;

    assign imem_addr = pc;
    assign pc_plus4  = XLEN'(pc + XLEN'(4));

    // Next-state and next-register values; redirect beats stall beats advance.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        id_valid_n     = id_valid;
        id_instr_n     = id_instr;
        id_pc_n        = id_pc;
        id_pc_plus4_n  = id_pc_plus4;
        fetch_fault_n  = fetch_fault;
        fetch_count_n  = fetch_count;
        case (state)
            BOOT: begin
                state_n = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    id_valid_n = 1'b0;
                    id_instr_n = NOP_INSN;
                    if (redirect_pc[1:0] == 2'b00) begin
                        pc_n = redirect_pc;
                    end else begin
                        state_n       = FAULT;
                        fetch_fault_n = 1'b1;
                    end
                end else if (!(id_valid && !id_ready)) begin
                    id_instr_n    = imem_instr;
                    id_pc_n       = pc;
                    id_pc_plus4_n = pc_plus4;
                    id_valid_n    = 1'b1;
                    pc_n          = pc_plus4;
                    fetch_count_n = XLEN'(fetch_count + XLEN'(1));
                end
            end
            FAULT: begin
                id_valid_n = 1'b0;
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSN;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            fetch_fault <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            id_valid    <= id_valid_n;
            id_instr    <= id_instr_n;
            id_pc       <= id_pc_n;
            id_pc_plus4 <= id_pc_plus4_n;
            fetch_fault <= fetch_fault_n;
            fetch_count <= fetch_count_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences,
// then random stall/redirect/reset traffic checked against a cycle-level reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_instr;
    logic        id_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, fetch_fault;
    logic [31:0] id_instr, id_pc, id_pc_plus4, fetch_count;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Memory image: word k holds an addi x(k+1),x0,(k+1)-style pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] k;
        k = (addr >> 2) + 32'd1;
        return (k << 20) | (k << 7) | 32'h13;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    // Reference model: mode 0 = just reset, 1 = fetching, 2 = faulted.
    int          m_mode = 0;
    logic [31:0] m_pc = 0, m_instr = NOP, m_ipc = 0, m_ip4 = 0, m_cnt = 0;
    logic        m_valid = 0, m_fault = 0;

    task automatic model_edge();
        if (rst) begin
            m_mode = 0; m_pc = 0; m_valid = 0; m_instr = NOP;
            m_ipc = 0; m_ip4 = 0; m_fault = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (redirect_valid && (redirect_pc % 4 == 0)) begin
                m_pc = redirect_pc; m_valid = 0; m_instr = NOP;
            end else if (redirect_valid) begin
                m_mode = 2; m_fault = 1; m_valid = 0; m_instr = NOP;
            end else if (m_valid && !id_ready) begin
                // stalled: nothing moves
            end else begin
                m_instr = mem_word(m_pc);
                m_ipc = m_pc;
                m_ip4 = m_pc + 32'd4;
                m_valid = 1;
                m_pc = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(m_valid));
        chk({tag, ".id_instr"}, id_instr, m_instr);
        chk({tag, ".id_pc"}, id_pc, m_ipc);
        chk({tag, ".id_pc_plus4"}, id_pc_plus4, m_ip4);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(m_fault));
        chk({tag, ".fetch_count"}, fetch_count, m_cnt);
    endtask

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_instr, e_pc, e_p4, e_addr, e_cnt;
        logic        e_fault;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rd, input logic v, input logic [31:0] rp,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                                input logic [31:0] e4, input logic [31:0] ea, input logic [31:0] ec,
                                input logic ef);
        vec_t t;
        t.rst = r; t.rdy = rd; t.rv = v; t.rpc = rp;
        t.e_valid = ev; t.e_instr = ei; t.e_pc = ep; t.e_p4 = e4;
        t.e_addr = ea; t.e_cnt = ec; t.e_fault = ef;
        return t;
    endfunction

    vec_t vt[15];

    initial begin
        rst = 1; id_ready = 1; redirect_valid = 0; redirect_pc = 0;

        //          rst rdy rv rpc           valid instr          pc     p4     addr   cnt fault
        vt[0]  = mk(1, 1, 0, 0,              0, NOP,           0,     0,     0,     0, 0);
        vt[1]  = mk(0, 1, 0, 0,              0, NOP,           0,     0,     0,     0, 0);
        vt[2]  = mk(0, 1, 0, 0,              1, 32'h00100093,  0,     4,     4,     1, 0);
        vt[3]  = mk(0, 1, 0, 0,              1, 32'h00200113,  4,     8,     8,     2, 0);
        vt[4]  = mk(0, 1, 0, 0,              1, 32'h00300193,  8,     'hC,   'hC,   3, 0);
        vt[5]  = mk(0, 0, 0, 0,              1, 32'h00300193,  8,     'hC,   'hC,   3, 0);
        vt[6]  = mk(0, 0, 0, 0,              1, 32'h00300193,  8,     'hC,   'hC,   3, 0);
        vt[7]  = mk(0, 0, 0, 0,              1, 32'h00300193,  8,     'hC,   'hC,   3, 0);
        vt[8]  = mk(0, 1, 0, 0,              1, 32'h00400213,  'hC,   'h10,  'h10,  4, 0);
        vt[9]  = mk(0, 0, 1, 32'h40,         0, NOP,           'hC,   'h10,  'h40,  4, 0);
        vt[10] = mk(0, 0, 0, 0,              1, 32'h01100893,  'h40,  'h44,  'h44,  5, 0);
        vt[11] = mk(0, 1, 1, 32'h42,         0, NOP,           'h40,  'h44,  'h44,  5, 1);
        vt[12] = mk(0, 1, 1, 32'h80,         0, NOP,           'h40,  'h44,  'h44,  5, 1);
        vt[13] = mk(0, 1, 0, 0,              0, NOP,           'h40,  'h44,  'h44,  5, 1);
        vt[14] = mk(1, 1, 0, 0,              0, NOP,           0,     0,     0,     0, 0);

        for (int i = 0; i < 15; i++) begin
            rst = vt[i].rst; id_ready = vt[i].rdy;
            redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc;
            step();
            chk($sformatf("vec%0d.id_valid", i), 32'(id_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d.id_instr", i), id_instr, vt[i].e_instr);
            chk($sformatf("vec%0d.id_pc", i), id_pc, vt[i].e_pc);
            chk($sformatf("vec%0d.id_pc_plus4", i), id_pc_plus4, vt[i].e_p4);
            chk($sformatf("vec%0d.imem_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d.fetch_count", i), fetch_count, vt[i].e_cnt);
            chk($sformatf("vec%0d.fetch_fault", i), 32'(fetch_fault), 32'(vt[i].e_fault));
        end

        // Address wrap at the top of the space.
        rst = 0; id_ready = 1; redirect_valid = 0;
        step();
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap.redir_valid", 32'(id_valid), 32'd0);
        chk("wrap.redir_addr", imem_addr, 32'hFFFF_FFFC);
        redirect_valid = 0;
        step();
        chk("wrap.id_valid", 32'(id_valid), 32'd1);
        chk("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap.id_pc_plus4", id_pc_plus4, 32'h0000_0000);
        chk("wrap.imem_addr", imem_addr, 32'h0000_0000);
        chk("wrap.id_instr", id_instr, mem_word(32'hFFFF_FFFC));

        // Reset asserted in the middle of a stall, then one BOOT cycle again.
        id_ready = 0;
        step();
        chk("rststall.pre_valid", 32'(id_valid), 32'd1);
        rst = 1;
        step();
        chk_model("rststall.reset");
        chk("rststall.id_valid", 32'(id_valid), 32'd0);
        chk("rststall.count", fetch_count, 32'd0);
        rst = 0; id_ready = 1;
        step();
        chk("rststall.boot_valid", 32'(id_valid), 32'd0);
        step();
        chk("rststall.first_valid", 32'(id_valid), 32'd1);
        chk("rststall.first_pc", id_pc, 32'd0);

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(99) < 3);
            id_ready = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 10);
            redirect_pc = {$urandom_range(255), 2'b00};
            if ($urandom_range(7) == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
            if ($urandom_range(19) == 0) redirect_pc = 32'hFFFF_FFF8 | {30'd0, redirect_pc[1:0]};
            step();
            chk_model($sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
